// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard and forwarding logic.
//
// Contents:
//   MIPS_REG_W   - register index width used by the shadow entries
//   fwd_sel_e    - EX operand-mux select encoding (11 is never produced)
//   dest_info_t  - destination-register summary of one in-flight instruction
//   DEST_BUBBLE  - the all-zero entry that stands for an empty pipeline slot
//   dest_match   - "does this in-flight instruction produce register r?"
package mips_pkg;

  localparam int MIPS_REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [MIPS_REG_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } dest_info_t;

  localparam dest_info_t DEST_BUBBLE = '{dest: '0, reg_write: 1'b0, mem_read: 1'b0};

  // Register 0 is hardwired to zero, so a write to it never produces a value
  // worth forwarding and never creates a dependency.
  function automatic logic dest_match(input dest_info_t entry,
                                      input logic [MIPS_REG_W-1:0] reg_idx);
    return entry.reg_write && (entry.dest != '0) && (entry.dest == reg_idx);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Forward-select decode for one source register of the instruction in ID.
//
// Ports:
//   sh_ex    in  shadow of the instruction currently in ID/EX
//   sh_mem   in  shadow of the instruction currently in EX/MEM
//   src      in  source register index read by the ID instruction
//   use_src  in  the ID instruction actually reads src as an operand
//   sel      out select the operand mux should use once this instruction is in EX
//
// The select is computed one stage early: by the time the ID instruction
// reaches EX, the ID/EX producer has moved to EX/MEM and the EX/MEM producer
// to MEM/WB, hence the apparent "off by one" in the mapping below.
module fwd_select
  import mips_pkg::*;
(
  input  dest_info_t            sh_ex,
  input  dest_info_t            sh_mem,
  input  logic [MIPS_REG_W-1:0] src,
  input  logic                  use_src,
  output fwd_sel_e              sel
);

  // Load status is irrelevant to which mux input carries the newest value;
  // the load-use stall in the top takes care of loads that are not ready yet.
  logic unused_mem_read;
  assign unused_mem_read = sh_ex.mem_read ^ sh_mem.mem_read;

  // The younger producer (ID/EX) wins when both older instructions write the
  // same register, since it holds the most recent value.
  always_comb begin
    sel = FWD_RF;
    if (use_src) begin
      if (dest_match(sh_ex, src)) begin
        sel = FWD_EX_MEM;
      end else if (dest_match(sh_mem, src)) begin
        sel = FWD_MEM_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline.
//
// Tracks the destination-register information of the instructions in ID/EX,
// EX/MEM and MEM/WB and produces registered operand-mux selects aligned to
// the instruction in EX. Detects load-use hazards (stall IF/ID, bubble into
// ID/EX), honours a whole-pipeline data-memory freeze and counts load-use
// stall cycles.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   id_valid       ID stage holds a real instruction
//   id_rs, id_rt   source registers of the ID instruction
//   id_uses_rt     ID instruction reads rt as an operand
//   id_dest        destination register of the ID instruction
//   id_reg_write   ID instruction writes the register file
//   id_mem_read    ID instruction is a load
//   mem_busy       data memory not ready; whole pipeline frozen
//   forward_a/b    operand selects for the EX instruction (00 RF, 01 MEM/WB, 10 EX/MEM)
//   stall_if_id    hold PC and IF/ID
//   flush_id_ex    load a bubble into ID/EX
//   stall_cnt      saturating count of load-use stall cycles
module hazard_fwd_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  mem_busy,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall_if_id,
  output logic                  flush_id_ex,
  output logic [CNT_W-1:0]      stall_cnt
);

  dest_info_t sh_ex;
  dest_info_t sh_mem;
  dest_info_t sh_wb;
  dest_info_t id_info;

  fwd_sel_e fwd_a_next;
  fwd_sel_e fwd_b_next;
  fwd_sel_e fwd_a_q;
  fwd_sel_e fwd_b_q;

  logic lu;

  // The MEM/WB shadow never drives a decision: a producer there while its
  // consumer is in ID is covered by the register file writing before it is
  // read. It is kept so the shadow chain mirrors the real pipeline.
  logic unused_wb;
  assign unused_wb = ^sh_wb;

  assign id_info = '{dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};

  // A load in ID/EX has no data until it leaves MEM, so a dependent
  // instruction in ID must wait exactly one cycle before it can forward from
  // MEM/WB. The rt match only counts when rt is really an operand.
  assign lu = id_valid & sh_ex.mem_read &
              (dest_match(sh_ex, id_rs) | (id_uses_rt & dest_match(sh_ex, id_rt)));

  // A memory freeze already holds IF/ID, and while frozen nothing may enter
  // ID/EX, so the bubble is only injected when the pipeline actually moves.
  assign stall_if_id = mem_busy | lu;
  assign flush_id_ex = lu & ~mem_busy;

  fwd_select u_fwd_a (
    .sh_ex   (sh_ex),
    .sh_mem  (sh_mem),
    .src     (id_rs),
    .use_src (1'b1),
    .sel     (fwd_a_next)
  );

  fwd_select u_fwd_b (
    .sh_ex   (sh_ex),
    .sh_mem  (sh_mem),
    .src     (id_rt),
    .use_src (id_uses_rt),
    .sel     (fwd_b_next)
  );

  assign forward_a = fwd_a_q;
  assign forward_b = fwd_b_q;

  // Shadow pipeline, registered selects and stall counter. A memory freeze
  // holds everything; a load-use stall advances the older stages while a
  // bubble (with RF selects) enters EX behind the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_ex     <= DEST_BUBBLE;
      sh_mem    <= DEST_BUBBLE;
      sh_wb     <= DEST_BUBBLE;
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      stall_cnt <= '0;
    end else if (!mem_busy) begin
      sh_wb  <= sh_mem;
      sh_mem <= sh_ex;
      if (lu) begin
        sh_ex   <= DEST_BUBBLE;
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
        if (stall_cnt != {CNT_W{1'b1}}) begin
          stall_cnt <= stall_cnt + CNT_W'(1);
        end
      end else if (id_valid) begin
        sh_ex   <= id_info;
        fwd_a_q <= fwd_a_next;
        fwd_b_q <= fwd_b_next;
      end else begin
        sh_ex   <= DEST_BUBBLE;
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed testbench for hazard_fwd_unit. A second instance with a 2-bit
// counter shares all stimulus so counter saturation is reached in a few stalls.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] id_dest;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       mem_busy;

  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall_if_id;
  logic        flush_id_ex;
  logic [15:0] stall_cnt;

  logic [1:0] sat_fa;
  logic [1:0] sat_fb;
  logic       sat_stall;
  logic       sat_flush;
  logic [1:0] sat_cnt;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int exp_cnt   = 0;

  hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .mem_busy     (mem_busy),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall_if_id  (stall_if_id),
    .flush_id_ex  (flush_id_ex),
    .stall_cnt    (stall_cnt)
  );

  hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .mem_busy     (mem_busy),
    .forward_a    (sat_fa),
    .forward_b    (sat_fb),
    .stall_if_id  (sat_stall),
    .flush_id_ex  (sat_flush),
    .stall_cnt    (sat_cnt)
  );

  always #5 clk = ~clk;

  // Present one instruction in ID.
  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ur, input logic [4:0] dest,
                          input logic rw, input logic mr);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = ur;
    id_dest      = dest;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic drive_nop();
    drive_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pipe();
    drive_nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    mem_busy = 1'b0;
    drive_id(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_cnt++;
    if (forward_a !== 2'b00) $display("[TB] FAIL reset_fwd_a got=%b exp=00", forward_a);
    else pass_cnt++;
    check_cnt++;
    if (forward_b !== 2'b00) $display("[TB] FAIL reset_fwd_b got=%b exp=00", forward_b);
    else pass_cnt++;
    check_cnt++;
    if (stall_if_id !== 1'b0) $display("[TB] FAIL reset_stall got=%b exp=0", stall_if_id);
    else pass_cnt++;
    check_cnt++;
    if (flush_id_ex !== 1'b0) $display("[TB] FAIL reset_flush got=%b exp=0", flush_id_ex);
    else pass_cnt++;
    check_cnt++;
    if (stall_cnt !== 16'd0) $display("[TB] FAIL reset_cnt got=%0d exp=0", stall_cnt);
    else pass_cnt++;
    drive_nop();
    tick();
  endtask

  // add r3,r1,r2 then sub r4,r3,r2: rs forwarded from EX/MEM.
  task automatic test_fwd_ex_mem();
    flush_pipe();
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd3, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    check_cnt++;
    if (stall_if_id !== 1'b0) $display("[TB] FAIL exmem_stall got=%b exp=0", stall_if_id);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (forward_a !== 2'b10) $display("[TB] FAIL exmem_fwd_a got=%b exp=10", forward_a);
    else pass_cnt++;
    check_cnt++;
    if (forward_b !== 2'b00) $display("[TB] FAIL exmem_fwd_b got=%b exp=00", forward_b);
    else pass_cnt++;
  endtask

  // add r3, nop, or r5,r3,r3: both operands from MEM/WB.
  task automatic test_fwd_mem_wb();
    flush_pipe();
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive_nop();
    tick();
    drive_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    check_cnt++;
    if (forward_a !== 2'b01) $display("[TB] FAIL memwb_fwd_a got=%b exp=01", forward_a);
    else pass_cnt++;
    check_cnt++;
    if (forward_b !== 2'b01) $display("[TB] FAIL memwb_fwd_b got=%b exp=01", forward_b);
    else pass_cnt++;
  endtask

  // add r3 twice, then use r3: the younger producer (EX/MEM) wins.
  task automatic test_back_to_back();
    flush_pipe();
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd6, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    check_cnt++;
    if (forward_a !== 2'b10) $display("[TB] FAIL b2b_fwd_a got=%b exp=10", forward_a);
    else pass_cnt++;
    check_cnt++;
    if (forward_b !== 2'b10) $display("[TB] FAIL b2b_fwd_b got=%b exp=10", forward_b);
    else pass_cnt++;
  endtask

  // lw r5 then add r6,r5,r1: one stall cycle, then MEM/WB forward on A.
  task automatic test_load_use();
    flush_pipe();
    drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd5, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    check_cnt++;
    if (stall_if_id !== 1'b1) $display("[TB] FAIL lu_stall got=%b exp=1", stall_if_id);
    else pass_cnt++;
    check_cnt++;
    if (flush_id_ex !== 1'b1) $display("[TB] FAIL lu_flush got=%b exp=1", flush_id_ex);
    else pass_cnt++;
    tick();
    exp_cnt++;
    check_cnt++;
    if (stall_if_id !== 1'b0) $display("[TB] FAIL lu_stall_clear got=%b exp=0", stall_if_id);
    else pass_cnt++;
    check_cnt++;
    if (forward_a !== 2'b00) $display("[TB] FAIL lu_bubble_fwd_a got=%b exp=00", forward_a);
    else pass_cnt++;
    check_cnt++;
    if (stall_cnt !== 16'(exp_cnt)) $display("[TB] FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (forward_a !== 2'b01) $display("[TB] FAIL lu_fwd_a got=%b exp=01", forward_a);
    else pass_cnt++;
    check_cnt++;
    if (forward_b !== 2'b00) $display("[TB] FAIL lu_fwd_b got=%b exp=00", forward_b);
    else pass_cnt++;
  endtask

  // lw r7 then a reader of r7 through rt: only a hazard when rt is used.
  task automatic test_load_use_rt();
    flush_pipe();
    drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd2, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    check_cnt++;
    if (stall_if_id !== 1'b0) $display("[TB] FAIL lurt_unused_stall got=%b exp=0", stall_if_id);
    else pass_cnt++;
    id_uses_rt = 1'b1;
    #1;
    check_cnt++;
    if (flush_id_ex !== 1'b1) $display("[TB] FAIL lurt_flush got=%b exp=1", flush_id_ex);
    else pass_cnt++;
    tick();
    exp_cnt++;
    tick();
    check_cnt++;
    if (forward_b !== 2'b01) $display("[TB] FAIL lurt_fwd_b got=%b exp=01", forward_b);
    else pass_cnt++;
    check_cnt++;
    if (forward_a !== 2'b00) $display("[TB] FAIL lurt_fwd_a got=%b exp=00", forward_a);
    else pass_cnt++;
  endtask

  // Three more load-use stalls: the 2-bit counter must stop at 3.
  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      flush_pipe();
      drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 5'd5, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
      tick();
      exp_cnt++;
      tick();
    end
    check_cnt++;
    if (stall_cnt !== 16'(exp_cnt)) $display("[TB] FAIL sat_main_cnt got=%0d exp=%0d", stall_cnt, exp_cnt);
    else pass_cnt++;
    check_cnt++;
    if (sat_cnt !== 2'd3) $display("[TB] FAIL sat_small_cnt got=%0d exp=3", sat_cnt);
    else pass_cnt++;
  endtask

  // Writes to r0, or producers without reg_write, never forward or stall.
  task automatic test_reg0_nowrite();
    flush_pipe();
    drive_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    check_cnt++;
    if (stall_if_id !== 1'b0) $display("[TB] FAIL r0_stall got=%b exp=0", stall_if_id);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (forward_a !== 2'b00 || forward_b !== 2'b00)
      $display("[TB] FAIL r0_fwd got=%b/%b exp=00/00", forward_a, forward_b);
    else pass_cnt++;
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    drive_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    check_cnt++;
    if (forward_a !== 2'b00 || forward_b !== 2'b00)
      $display("[TB] FAIL nowrite_fwd got=%b/%b exp=00/00", forward_a, forward_b);
    else pass_cnt++;
  endtask

  // Memory freeze during a load-use hazard, then a reset in the middle of it.
  task automatic test_mem_busy_reset();
    flush_pipe();
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    check_cnt++;
    if (forward_a !== 2'b10) $display("[TB] FAIL busy_pre_fwd_a got=%b exp=10", forward_a);
    else pass_cnt++;
    drive_id(1'b1, 5'd5, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_cnt++;
      if (stall_if_id !== 1'b1 || flush_id_ex !== 1'b0)
        $display("[TB] FAIL busy_ctrl[%0d] got=%b%b exp=10", i, stall_if_id, flush_id_ex);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (forward_a !== 2'b10 || stall_cnt !== 16'(exp_cnt))
        $display("[TB] FAIL busy_hold[%0d] got fwd_a=%b cnt=%0d exp fwd_a=10 cnt=%0d",
                 i, forward_a, stall_cnt, exp_cnt);
      else pass_cnt++;
    end
    mem_busy = 1'b0;
    #1;
    check_cnt++;
    if (stall_if_id !== 1'b1 || flush_id_ex !== 1'b1)
      $display("[TB] FAIL busy_release got=%b%b exp=11", stall_if_id, flush_id_ex);
    else pass_cnt++;
    rst      = 1'b1;
    mem_busy = 1'b1;
    tick();
    rst      = 1'b0;
    mem_busy = 1'b0;
    exp_cnt  = 0;
    #1;
    check_cnt++;
    if (forward_a !== 2'b00 || forward_b !== 2'b00 || stall_if_id !== 1'b0 || flush_id_ex !== 1'b0)
      $display("[TB] FAIL midreset_ctrl got=%b/%b/%b/%b exp=00/00/0/0",
               forward_a, forward_b, stall_if_id, flush_id_ex);
    else pass_cnt++;
    check_cnt++;
    if (stall_cnt !== 16'd0 || sat_cnt !== 2'd0)
      $display("[TB] FAIL midreset_cnt got=%0d/%0d exp=0/0", stall_cnt, sat_cnt);
    else pass_cnt++;
  endtask

  initial begin
    $display("[TB] hazard_fwd_unit directed test start");
    test_reset();
    test_fwd_ex_mem();
    test_fwd_mem_wb();
    test_back_to_back();
    test_load_use();
    test_load_use_rt();
    test_saturation();
    test_reg0_nowrite();
    test_mem_busy_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
